// File: rtl/pipe_collector.sv
// Bit-plane column collector: captures WIDTH columns of WORDS bits, then streams
// the reassembled WORDS words out one per cycle over a valid/ready handshake.

module pipe_collector_lane #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] wr_sel,
  input  logic             din,
  output logic [WIDTH-1:0] row
);
  // One word of the buffer; the selected bit takes din, others hold.
  always_ff @(posedge clk)
    row <= (row & ~wr_sel) | ({WIDTH{din}} & wr_sel);
endmodule

module pipe_collector #(
  parameter int WORDS = 64,
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      num,
  input  logic [WORDS-1:0] pipe,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [5:0]       out_index,
  output logic             done,
  output logic             err
);
  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t                        state;
  logic [WIDTH-1:0]              got;
  logic [WIDTH-1:0]              col_sel;
  logic [WIDTH-1:0]              wr_sel;
  logic [WIDTH-1:0]              got_nxt;
  logic [5:0]                    idx;
  logic [WORDS-1:0][WIDTH-1:0]   buffer;

  // Column num lands on word bit WIDTH-1-num; out-of-range num yields no select.
  always_comb begin
    col_sel = '0;
    for (int c = 0; c < WIDTH; c++)
      col_sel[c] = (num == 32'(WIDTH - 1 - c));
  end

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == DRAIN);
  assign wr_sel    = (in_valid && in_ready) ? col_sel : '0;
  assign got_nxt   = got | col_sel;
  assign out_word  = out_valid ? buffer[idx] : '0;
  assign out_index = idx;

  for (genvar n = 0; n < WORDS; n++) begin : g_lane
    pipe_collector_lane #(.WIDTH(WIDTH)) u_lane (
      .clk    (clk),
      .wr_sel (wr_sel),
      .din    (pipe[n]),
      .row    (buffer[n])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      got   <= '0;
      idx   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        COLLECT: begin
          if (in_valid) begin
            if (|col_sel) begin
              got <= got_nxt;
              if (&got_nxt) begin
                state <= DRAIN;
                idx   <= '0;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (idx == 6'(WORDS - 1)) begin
              idx   <= '0;
              got   <= '0;
              done  <= 1'b1;
              state <= COLLECT;
            end else begin
              idx <= idx + 6'd1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_collector.sv
// Bench for pipe_collector: column tables drive batches, a scoreboard queue
// holds the expected word stream, and drains compare against it.

module tb_pipe_collector;
  localparam int WORDS = 64;
  localparam int WIDTH = 25;

  typedef struct {
    logic [31:0] num;
    logic [63:0] pipe;
    logic        exp_err;
    logic        exp_valid;
  } vec_t;

  typedef struct {
    logic [5:0]       idx;
    logic [WIDTH-1:0] word;
  } scb_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      num;
  logic [WORDS-1:0] pipe;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic [5:0]       out_index;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [WIDTH-1:0] wd [WORDS];
  scb_t             q [$];
  vec_t             vt [27];

  pipe_collector #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .pipe      (pipe),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_index (out_index),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] col_of(input int c);
    logic [63:0] r;
    for (int n = 0; n < WORDS; n++) r[n] = wd[n][WIDTH-1-c];
    return r;
  endfunction

  task automatic send_col(input logic [31:0] n, input logic [63:0] d);
    chk("col_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    num      = n;
    pipe     = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_batch();
    scb_t e;
    for (int n = 0; n < WORDS; n++) begin
      e.idx  = 6'(n);
      e.word = wd[n];
      q.push_back(e);
    end
  endtask

  task automatic first_word_chk();
    chk("first_out_valid", 64'(out_valid), 64'd1);
    chk("first_in_ready", 64'(in_ready), 64'd0);
    chk("first_out_index", 64'(out_index), 64'd0);
  endtask

  task automatic load_batch();
    for (int k = 0; k < WIDTH; k++) begin
      if (k < WIDTH - 1) chk("collect_no_valid_pre", 64'(out_valid), 64'd0);
      send_col(32'(k), col_of(k));
    end
    first_word_chk();
    push_batch();
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1
  task automatic drain(input int mode, input int nwords);
    int               xf = 0;
    int               cn = 0;
    int               early = 0;
    logic             pv = 1'b0;
    logic [WIDTH-1:0] pw = '0;
    logic [5:0]       pi = '0;
    scb_t             e;
    while (xf < nwords && cn < 400) begin
      out_ready = (mode == 0) ? 1'b1 : ((cn % 4 == 0) || (cn % 4 == 3));
      if (pv) begin
        chk("stall_word", 64'(out_word), 64'(pw));
        chk("stall_index", 64'(out_index), 64'(pi));
      end
      if (done) early++;
      chk("drain_valid", 64'(out_valid), 64'd1);
      if (out_valid && out_ready) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("word", 64'(out_word), 64'(e.word));
          chk("index", 64'(out_index), 64'(e.idx));
        end else begin
          errors++;
          $display("FAIL scb_underflow actual=word %0h expected=none", out_word);
        end
        xf++;
      end
      pv = out_valid && !out_ready;
      pw = out_word;
      pi = out_index;
      step();
      cn++;
    end
    out_ready = 1'b0;
    chk("drain_transfers", 64'(xf), 64'(nwords));
    chk("early_done", 64'(early), 64'd0);
    if (nwords == WORDS) begin
      chk("done_pulse", 64'(done), 64'd1);
      chk("end_out_valid", 64'(out_valid), 64'd0);
      chk("end_in_ready", 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    int c0;
    int p;
    rst_n = 1'b0; in_valid = 1'b0; num = '0; pipe = '0; out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_word", 64'(out_word), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    step();

    // Basic batch: word n = n*3+1, timing of done
    for (int n = 0; n < WORDS; n++) wd[n] = WIDTH'(n * 3 + 1);
    c0 = -1;
    for (int k = 0; k < WIDTH; k++) begin
      send_col(32'(k), col_of(k));
      if (k == 0) c0 = cyc;
    end
    first_word_chk();
    push_batch();
    drain(0, WORDS);
    chk("done_cycle", 64'(cyc - c0), 64'd88);
    step();
    chk("done_one_cycle", 64'(done), 64'd0);

    // Reverse order with a duplicate column 5 (ones then zeros)
    for (int n = 0; n < WORDS; n++) begin
      wd[n] = WIDTH'($urandom);
      wd[n][19] = 1'b0;
    end
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (k == 5) begin
        send_col(32'd5, '1);
        chk("dup_no_valid", 64'(out_valid), 64'd0);
      end
      send_col(32'(k), col_of(k));
      if (k > 0) chk("ooo_no_valid", 64'(out_valid), 64'd0);
    end
    first_word_chk();
    push_batch();
    drain(0, WORDS);

    // Backpressure
    for (int n = 0; n < WORDS; n++) wd[n] = WIDTH'($urandom);
    load_batch();
    drain(1, WORDS);

    // Invalid indices mid-batch, table driven
    for (int n = 0; n < WORDS; n++) wd[n] = WIDTH'(n * 5 + 7) ^ 25'h1A5A5A5;
    p = 0;
    for (int c = 0; c < 13; c++) begin
      vt[p] = '{num: 32'(c), pipe: col_of(c), exp_err: 1'b0, exp_valid: 1'b0};
      p++;
    end
    vt[p] = '{num: 32'd25, pipe: '1, exp_err: 1'b1, exp_valid: 1'b0};
    p++;
    for (int c = 13; c < 19; c++) begin
      vt[p] = '{num: 32'(c), pipe: col_of(c), exp_err: 1'b1, exp_valid: 1'b0};
      p++;
    end
    vt[p] = '{num: 32'd100, pipe: '1, exp_err: 1'b1, exp_valid: 1'b0};
    p++;
    for (int c = 19; c < WIDTH; c++) begin
      vt[p] = '{num: 32'(c), pipe: col_of(c), exp_err: 1'b1, exp_valid: (c == WIDTH - 1)};
      p++;
    end
    for (int i = 0; i < 27; i++) begin
      send_col(vt[i].num, vt[i].pipe);
      chk("vec_err", 64'(err), 64'(vt[i].exp_err));
      chk("vec_valid", 64'(out_valid), 64'(vt[i].exp_valid));
    end
    push_batch();
    drain(0, WORDS);
    chk("err_sticky", 64'(err), 64'd1);

    // Reset mid-drain after word 10
    for (int n = 0; n < WORDS; n++) wd[n] = WIDTH'($urandom);
    load_batch();
    drain(0, 11);
    chk("pre_rst_index", 64'(out_index), 64'd11);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_index", 64'(out_index), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    q.delete();
    step();
    rst_n = 1'b1;
    step();
    for (int n = 0; n < WORDS; n++) wd[n] = WIDTH'($urandom);
    load_batch();
    drain(0, WORDS);

    // in_valid held through DRAIN must not capture; column accepted after done
    for (int n = 0; n < WORDS; n++) begin
      wd[n] = WIDTH'($urandom);
      wd[n][WIDTH-1] = 1'b0;
    end
    load_batch();
    in_valid = 1'b1;
    num      = 32'd0;
    pipe     = '1;
    drain(0, WORDS);
    step();
    in_valid = 1'b0;
    chk("post_cap_in_ready", 64'(in_ready), 64'd1);
    chk("post_cap_no_valid", 64'(out_valid), 64'd0);
    for (int n = 0; n < WORDS; n++) begin
      wd[n] = WIDTH'($urandom);
      wd[n][WIDTH-1] = 1'b1;
    end
    for (int k = 1; k < WIDTH; k++) send_col(32'(k), col_of(k));
    first_word_chk();
    push_batch();
    drain(0, WORDS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_collector.md
# pipe_collector

Collects bit-plane result columns and reassembles them into words. Each input transfer carries one 64-bit column: bit n of the column belongs to word n at bit position selected by `num`, using the same MSB-first column numbering as the bit-serial input path. Once all WIDTH columns are captured, the block streams the reassembled words out in order, one per cycle, with a valid/ready handshake. It is the output-side counterpart to the per-bit column loader and sits between the bit-serial datapath and the result sink.

## Interface

Parameters:
- `WORDS`, 64: words per batch and column width in bits.
- `WIDTH`, 25: bits per word and number of columns per batch.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  a column is present on `pipe`/`num`.
- `in_ready`  out  1  block accepts a column this cycle.
- `num`  in  32  column index, 0..WIDTH-1; column `num` maps to word bit WIDTH-1-`num`.
- `pipe`  in  WORDS  column data; `pipe[n]` goes to word n.
- `out_valid`  out  1  `out_word` is valid.
- `out_ready`  in  1  the sink accepts `out_word`.
- `out_word`  out  WIDTH  reassembled word.
- `out_index`  out  6  index (0..WORDS-1) of `out_word`.
- `done`  out  1  one-cycle pulse after the last word of a batch is accepted.
- `err`  out  1  sticky flag: a column with out-of-range `num` was received.

## Operation

- Storage:
  - WORDS x WIDTH bit buffer.
  - WIDTH-bit column mask `got`.
  - State register with two states: COLLECT and DRAIN.
- COLLECT state:
  - `in_ready` is 1 and `out_valid` is 0.
  - Accept condition: `in_valid && in_ready` at a clock edge.
  - On accept with `num < WIDTH`:
    - For each n, write `pipe[n]` into buffer[n][WIDTH-1-num].
    - Set `got[WIDTH-1-num]`.
  - Duplicate column (mask bit already set): the new data overwrites the buffered data; the mask is unchanged.
  - On accept with `num >= WIDTH`: the column is dropped, `err` is set, and the mask is unchanged.
  - When the mask becomes all ones, go to DRAIN with the output index at 0.
- DRAIN state:
  - `in_ready` is 0 and `out_valid` is 1.
  - `out_word` = buffer[out_index] and `out_index` = the current index.
  - When `out_valid && out_ready`, increment the index.
  - When the word at index WORDS-1 is accepted:
    - Pulse `done`.
    - Clear `got`.
    - Return to COLLECT.
  - While `out_ready` is 0, `out_word` and `out_index` hold stable.
- `err` clears only on reset.
- Reset (asynchronous, at any time, including mid-collect or mid-drain):
  - State returns to COLLECT; `got`, the output index and `err` clear.
  - The partially collected or partially drained batch is discarded.
  - Buffer contents are not reset.
- Reset values:
  - `in_ready`=1 once `rst_n` deasserts.
  - `out_valid`=0, `out_word`=0, `out_index`=0, `done`=0, `err`=0.

## Timing

- Column accept takes one cycle; full throughput is one column per cycle in COLLECT.
- Latency to first output:
  - The column completing the mask is accepted at edge k.
  - `out_valid` is 1 and `in_ready` is 0 from just after edge k.
  - Word 0 is presented in the same cycle.
- Drain throughput: one word per cycle when `out_ready` is held high. A full drain takes exactly WORDS cycles.
- End of batch:
  - The final word is accepted at edge m.
  - Just after edge m: `done`=1 for one cycle, `out_valid`=0, `in_ready`=1.
  - A new column can be accepted at edge m+1.
- Minimum batch: WIDTH + WORDS cycles (25 + 64 = 89 with the defaults).
- `in_valid` during DRAIN is ignored; the source must hold its column until `in_ready` is 1.

## Test plan

- **Basic batch:** send columns num=0..24 in order, where column num carries bit (24-num) of word n = n*3+1.
  - Expect words 0..63 equal to n*3+1 (25-bit), `out_index` 0..63 in order.
  - Expect `done` pulsed once, at cycle 89 from the first column.
- **Out-of-order and duplicate:** send columns in the order 24 down to 0, with column 5 sent twice (first all ones, then all zeros).
  - Expect bit 19 = 0 in every word.
  - Expect DRAIN entered only after all 25 distinct columns are received.
- **Backpressure:** toggle `out_ready` 1,0,0,1 repeatedly.
  - Expect `out_word` and `out_index` stable while stalled.
  - Expect no word skipped or duplicated; exactly 64 transfers.
- **Invalid index:** send num=25 and num=100 mid-batch.
  - Expect `err`=1 held sticky, the mask unaffected, and the batch completing normally with the correct data.
- **Reset mid-drain:** assert `rst_n`=0 after word 10 is accepted.
  - Expect immediately: `out_valid`=0, `in_ready`=1, `out_index`=0, `err`=0.
  - A fresh 25-column batch then drains words 0..63 correctly.
- **Input during DRAIN:** hold `in_valid`=1 with num=0 and data all ones throughout DRAIN.
  - Expect no capture and the batch data unchanged.
  - Expect the column accepted at the first cycle after `done`.
